// File: rtl/serial_addsub_if.sv
// Request/response bundle for serial_addsub; ovf is present only when
// SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, sub, input busy, done, result, cout, ovf);
  modport slave  (input start, a, b, sub, output busy, done, result, cout, ovf);
`else
  modport master (output start, a, b, sub, input busy, done, result, cout);
  modport slave  (input start, a, b, sub, output busy, done, result, cout);
`endif
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, WIDTH cycles per op.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [WIDTH-1:0] part_q, part_d, result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             accept, last_bit, sum_bit, carry_nxt;

  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign last_bit  = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));
  assign sum_bit   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
  assign carry_nxt = (op_a_q[0] & op_b_q[0]) | (carry_q & (op_a_q[0] ^ op_b_q[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = accept ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (state_q)
      StRun:   bus.busy = 1'b1;
      StDone:  bus.done = 1'b1;
      default: ;
    endcase
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;
  assign bus.ovf = ovf_q;
`endif

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (accept) begin
      op_a_d  = bus.a;
      op_b_d  = bus.b ^ {WIDTH{bus.sub}};
      part_d  = '0;
      cnt_d   = '0;
      carry_d = bus.sub;
    end else if (state_q == StRun) begin
      op_a_d  = op_a_q >> 1;
      op_b_d  = op_b_q >> 1;
      part_d  = {sum_bit, part_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CntW'(1);
      carry_d = carry_nxt;
      if (last_bit) begin
        result_d = {sum_bit, part_q[WIDTH-1:1]};
        cout_d   = carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d    = carry_q ^ carry_nxt;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.cout   = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH=8: directed and random ops against an arithmetic model.
module tb_serial_addsub;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, result} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, v;
    logic [7:0] r;
    logic c, o;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (s) begin
      r = a - b;
      c = (ua >= ub);
      v = sa - sb;
    end else begin
      r = a + b;
      c = (ua + ub) > 255;
      v = sa + sb;
    end
    o = (v > 127) || (v < -128);
    return {o, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs(input bit with_start);
    bus.start = with_start ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.sub   = 1'($urandom_range(0, 1));
  endtask

  // Drive a request; the next edge accepts it (from IDLE or DONE).
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    tick();
    check_eq("accept_busy", 64'(bus.busy), 64'd1);
    check_eq("accept_done", 64'(bus.done), 64'd0);
    scramble_inputs(1'b1);
  endtask

  // Seven more RUN cycles, then DONE must appear exactly at edge k+WIDTH.
  task automatic wait_done(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [9:0] exp;
    exp = ref_op(a, b, s);
    for (int i = 1; i < int'(W); i++) begin
      tick();
      check_eq("run_busy", 64'(bus.busy), 64'd1);
      check_eq("run_done", 64'(bus.done), 64'd0);
      scramble_inputs(1'b1);
    end
    tick();
    bus.start = 1'b0;
    check_eq("done_pulse", 64'(bus.done), 64'd1);
    check_eq("done_busy", 64'(bus.busy), 64'd0);
    check_eq("result", 64'(bus.result), 64'(exp[7:0]));
    check_eq("cout", 64'(bus.cout), 64'(exp[8]));
`ifdef SERIAL_ADDSUB_OVF_EN
    check_eq("ovf", 64'(bus.ovf), 64'(exp[9]));
`endif
  endtask

  task automatic settle_idle(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic [9:0] exp;
    exp = ref_op(a, b, s);
    tick();
    check_eq("idle_done", 64'(bus.done), 64'd0);
    check_eq("idle_busy", 64'(bus.busy), 64'd0);
    check_eq("hold_result", 64'(bus.result), 64'(exp[7:0]));
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    tick();
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_result", 64'(bus.result), 64'd0);
    check_eq("rst_cout", 64'(bus.cout), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_after_rst", 64'(bus.busy), 64'd0);

    launch(8'h3C, 8'h45, 1'b0);
    wait_done(8'h3C, 8'h45, 1'b0);
    settle_idle(8'h3C, 8'h45, 1'b0);
    launch(8'hFF, 8'h01, 1'b0);
    wait_done(8'hFF, 8'h01, 1'b0);
    settle_idle(8'hFF, 8'h01, 1'b0);
    launch(8'h10, 8'h20, 1'b1);
    wait_done(8'h10, 8'h20, 1'b1);
    settle_idle(8'h10, 8'h20, 1'b1);
    launch(8'h80, 8'h01, 1'b1);
    wait_done(8'h80, 8'h01, 1'b1);
    launch(8'h05, 8'h03, 1'b1);
    wait_done(8'h05, 8'h03, 1'b1);
    settle_idle(8'h05, 8'h03, 1'b1);
    launch(8'h12, 8'h34, 1'b0);
    wait_done(8'h12, 8'h34, 1'b0);
    settle_idle(8'h12, 8'h34, 1'b0);

    // Abort mid-operation with an asynchronous reset between edges.
    launch(8'h3C, 8'h45, 1'b0);
    wait_done(8'h3C, 8'h45, 1'b0);
    launch(8'h77, 8'h11, 1'b0);
    bus.start = 1'b0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", 64'(bus.busy), 64'd0);
    check_eq("arst_done", 64'(bus.done), 64'd0);
    check_eq("arst_result", 64'(bus.result), 64'd0);
    check_eq("arst_cout", 64'(bus.cout), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(W) + 2; i++) begin
      tick();
      check_eq("post_abort_done", 64'(bus.done), 64'd0);
      check_eq("post_abort_busy", 64'(bus.busy), 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      launch(ra, rb, rs);
      wait_done(ra, rb, rs);
      if ($urandom_range(0, 1) == 0) settle_idle(ra, rb, rs);
    end
    settle_idle(ra, rb, rs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request; sampled only in IDLE or DONE.
REQ-005 Port: a  input  WIDTH  first operand; latched on accepted start.
REQ-006 Port: b  input  WIDTH  second operand; latched on accepted start.
REQ-007 Port: sub  input  1  0 = a+b, 1 = a-b; latched on accepted start.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse; high exactly while in DONE.
REQ-010 Port: result  output  WIDTH  registered sum/difference; holds last completed value.
REQ-011 Port: cout  output  1  final carry; for sub, 1 = no borrow (a >= b unsigned).

Function
REQ-012 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE/DONE with start=1 at edge k: latch a, b^{WIDTH{sub}}, sub; set carry=sub, bit counter=0; next state RUN.
REQ-014 DONE with start=0 -> IDLE next edge; IDLE with start=0 -> stay IDLE.
REQ-015 RUN: each edge computes one bit LSB-first (full adder of operand-A bit 0, operand-B bit 0, carry), shifts both operand registers right by one, shifts sum bit into MSB of a partial-result register, updates carry, increments counter.
REQ-016 Counter SHALL be ceil(log2(WIDTH)) bits; when counter==WIDTH-1 on a RUN edge, that edge is the last bit and next state is DONE.
REQ-017 Latency: start accepted at edge k -> bits processed at edges k+1..k+WIDTH -> DONE entered at edge k+WIDTH; done high in the cycle following edge k+WIDTH.
REQ-018 result and cout SHALL update only at the edge entering DONE, and hold until the next completion or reset.
REQ-019 start during RUN SHALL be ignored; operand/sub input changes during RUN SHALL have no effect.
REQ-020 start in DONE SHALL be accepted (back-to-back op): done still pulses that cycle, next state RUN.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; result equals (a + b) or (a - b) truncated to WIDTH bits.
REQ-022 busy and done SHALL never be high simultaneously.

Reset
REQ-023 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, counter 0, carry 0, operand and partial registers 0.
REQ-024 Output reset values: busy=0, done=0, result=0, cout=0 (and ovf=0 when present).
REQ-025 Reset during RUN SHALL abort the operation with no done pulse and no result update.
REQ-026 First accepted start SHALL be the first rising edge with rst_n=1 and start=1.

Configuration
REQ-027 Macro SERIAL_ADDSUB_OVF_EN SHALL control a signed overflow output.
REQ-028 With SERIAL_ADDSUB_OVF_EN defined: extra port ovf  output  1, = carry-into-MSB XOR carry-out-of-MSB of the last bit, registered and updated with result (REQ-018).
REQ-029 Without SERIAL_ADDSUB_OVF_EN: port ovf and its logic SHALL not exist; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 Reset, start a=0x3C b=0x45 sub=0 at edge k -> busy high edges k..k+7, done pulse after edge k+8, result=0x81, cout=0, ovf=1.
REQ-031 a=0xFF b=0x01 sub=0 -> result=0x00, cout=1, ovf=0; a=0x10 b=0x20 sub=1 -> result=0xF0, cout=0, ovf=0.
REQ-032 a=0x80 b=0x01 sub=1 -> result=0x7F, cout=1, ovf=1; then start held high in DONE with a=0x05 b=0x03 sub=1 -> second done 9 cycles later, result=0x02, cout=1.
REQ-033 Start a=0x12 b=0x34 sub=0, pulse start with a=0xFF b=0xFF and toggle sub at edges k+3 and k+5 -> ignored, result=0x46, single done pulse.
REQ-034 Complete op (result=0x81), start new op, drop rst_n asynchronously mid-cycle at k+4 -> outputs 0 before next edge, no done pulse, state IDLE after release.
